// File: rtl/z80_io_initiator.sv
// Z80-style I/O bus initiator: turns one command into a single IN or OUT
// bus cycle (T1, T2, at least one TW, T3). Each T-state lasts T_CLKS clks.
// The cycle finishes with a one-clk response that carries the read data and a
// flag saying whether the cycle ran out of wait states.
module z80_io_initiator #(
  parameter int T_CLKS   = 6,
  parameter int WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_port,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic [7:0] A,
  output logic [7:0] cd_out,
  output logic       cd_oe,
  input  logic [7:0] cd_in,
  output logic       iorq_n,
  output logic       rd_n,
  output logic       wr_n,
  input  logic       wait_n
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(T_CLKS - 1);
  localparam logic [7:0] TW_LAST  = 8'(WAIT_MAX);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tw_cnt_q, tw_cnt_d;
  logic       is_write_q, is_write_d;
  logic       timeout_q, timeout_d;
  logic [7:0] a_q, a_d;
  logic [7:0] cd_out_q, cd_out_d;
  logic       cd_oe_q, cd_oe_d;
  logic       iorq_n_q, iorq_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_timeout_q, rsp_timeout_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       wait_s1_q, wait_s1_d;
  logic       wait_s2_q, wait_s2_d;
  logic       cnt_last;

  // Every output comes straight from a flop (or from the state flop only).
  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign A           = a_q;
  assign cd_out      = cd_out_q;
  assign cd_oe       = cd_oe_q;
  assign iorq_n      = iorq_n_q;
  assign rd_n        = rd_n_q;
  assign wr_n        = wr_n_q;

  // Register all state; reset puts the bus idle with strobes released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      tw_cnt_q      <= 8'd0;
      is_write_q    <= 1'b0;
      timeout_q     <= 1'b0;
      a_q           <= 8'd0;
      cd_out_q      <= 8'd0;
      cd_oe_q       <= 1'b0;
      iorq_n_q      <= 1'b1;
      rd_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= 8'd0;
      wait_s1_q     <= 1'b1;
      wait_s2_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tw_cnt_q      <= tw_cnt_d;
      is_write_q    <= is_write_d;
      timeout_q     <= timeout_d;
      a_q           <= a_d;
      cd_out_q      <= cd_out_d;
      cd_oe_q       <= cd_oe_d;
      iorq_n_q      <= iorq_n_d;
      rd_n_q        <= rd_n_d;
      wr_n_q        <= wr_n_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_data_q    <= rsp_data_d;
      wait_s1_q     <= wait_s1_d;
      wait_s2_q     <= wait_s2_d;
    end
  end

  // Next-state and bus-output logic; each T-state advances on the last clk of its T_CLKS window.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tw_cnt_d      = tw_cnt_q;
    is_write_d    = is_write_q;
    timeout_d     = timeout_q;
    a_d           = a_q;
    cd_out_d      = cd_out_q;
    cd_oe_d       = cd_oe_q;
    iorq_n_d      = iorq_n_q;
    rd_n_d        = rd_n_q;
    wr_n_d        = wr_n_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_data_d    = rsp_data_q;
    wait_s1_d     = wait_n;
    wait_s2_d     = wait_s1_q;
    cnt_last      = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE) begin
      cnt_d = cnt_last ? 4'd0 : cnt_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (cmd_valid) begin
          // Command fields are captured once here; later cmd_* changes are ignored.
          state_d    = S_T1;
          is_write_d = cmd_write;
          a_d        = cmd_port;
          timeout_d  = 1'b0;
          tw_cnt_d   = 8'd0;
          if (cmd_write) begin
            cd_out_d = cmd_data;
            cd_oe_d  = 1'b1;
          end
        end
      end
      S_T1: begin
        if (cnt_last) begin
          state_d  = S_T2;
          iorq_n_d = 1'b0;
          if (is_write_q) wr_n_d = 1'b0;
          else            rd_n_d = 1'b0;
        end
      end
      S_T2: begin
        // The first TW is unconditional: the automatic I/O wait state.
        if (cnt_last) begin
          state_d  = S_TW;
          tw_cnt_d = 8'd1;
        end
      end
      S_TW: begin
        if (cnt_last) begin
          if (wait_s2_q) begin
            state_d = S_T3;
          end else if (tw_cnt_q == TW_LAST) begin
            state_d   = S_T3;
            timeout_d = 1'b1;
          end else begin
            tw_cnt_d = tw_cnt_q + 8'd1;
          end
        end
      end
      S_T3: begin
        if (cnt_last) begin
          state_d       = S_IDLE;
          iorq_n_d      = 1'b1;
          rd_n_d        = 1'b1;
          wr_n_d        = 1'b1;
          cd_oe_d       = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = timeout_q;
          if (!is_write_q) rsp_data_d = cd_in;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_z80_io_initiator.sv
// Bench for z80_io_initiator: two instances share all inputs (WAIT_MAX 255 and 3).
// A timeline model predicts every output on every clk; directed tests add
// literal expectations for latencies, strobe durations and data.
module tb_z80_io_initiator;

  localparam int TC = 6;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_write;
  logic [7:0] cmd_port;
  logic [7:0] cmd_data;
  logic [7:0] cd_in;
  logic       wait_n;

  logic       cmd_ready0, rsp_valid0, rsp_timeout0, cd_oe0, iorq_n0, rd_n0, wr_n0;
  logic [7:0] rsp_data0, A0, cd_out0;
  logic       cmd_ready1, rsp_valid1, rsp_timeout1, cd_oe1, iorq_n1, rd_n1, wr_n1;
  logic [7:0] rsp_data1, A1, cd_out1;

  z80_io_initiator #(.T_CLKS(TC), .WAIT_MAX(255)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
    .cmd_write(cmd_write), .cmd_port(cmd_port), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_timeout(rsp_timeout0),
    .A(A0), .cd_out(cd_out0), .cd_oe(cd_oe0), .cd_in(cd_in),
    .iorq_n(iorq_n0), .rd_n(rd_n0), .wr_n(wr_n0), .wait_n(wait_n)
  );

  z80_io_initiator #(.T_CLKS(TC), .WAIT_MAX(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_write(cmd_write), .cmd_port(cmd_port), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_timeout(rsp_timeout1),
    .A(A1), .cd_out(cd_out1), .cd_oe(cd_oe1), .cd_in(cd_in),
    .iorq_n(iorq_n1), .rd_n(rd_n1), .wr_n(wr_n1), .wait_n(wait_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;   // index of the next rising edge

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
  endtask

  // ---------------- timeline model ----------------
  // Per accepted command: T1 and T2 take 2*TC clks, then TW states of TC clks
  // each until the wait_n seen two edges earlier is high (or the WAIT_MAX-th
  // TW ends low), then T3 of TC clks, then one response clk in idle.
  logic whist [0:8191];
  int   wmax  [2] = '{255, 3};
  bit   m_act [2];
  bit   m_wr  [2];
  bit   m_to  [2];
  bit   m_rsp [2];
  bit   m_rto [2];
  int   m_rel [2];
  int   m_t3s [2];
  logic [7:0] m_a [2];
  logic [7:0] m_cdout [2];
  logic [7:0] m_rdata [2];

  initial begin
    int  k;
    logic w;
    bit  was_idle;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_wr[i] = 0; m_to[i] = 0; m_rsp[i] = 0; m_rto[i] = 0;
      m_rel[i] = 0; m_t3s[i] = -1; m_a[i] = 8'h00; m_cdout[i] = 8'h00; m_rdata[i] = 8'h00;
    end
    forever begin
      @(posedge clk);
      if (cyc < 8192) whist[cyc] = reset_n ? wait_n : 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (!reset_n) begin
          m_act[i] = 0; m_rsp[i] = 0; m_rto[i] = 0; m_to[i] = 0;
          m_a[i] = 8'h00; m_cdout[i] = 8'h00; m_rdata[i] = 8'h00;
        end else begin
          was_idle = !m_act[i];
          m_rsp[i] = 0;
          m_rto[i] = 0;
          if (m_act[i]) begin
            m_rel[i]++;
            if (m_t3s[i] < 0 && m_rel[i] >= 3*TC && (m_rel[i] % TC) == 0) begin
              k = (m_rel[i] - 2*TC) / TC;
              w = (cyc >= 2) ? whist[cyc-2] : 1'b1;
              if (w || k == wmax[i]) begin
                m_t3s[i] = m_rel[i];
                m_to[i]  = !w;
              end
            end else if (m_t3s[i] >= 0 && m_rel[i] == m_t3s[i] + TC) begin
              m_act[i] = 0;
              m_rsp[i] = 1;
              m_rto[i] = m_to[i];
              if (!m_wr[i]) m_rdata[i] = cd_in;
            end
          end
          if (was_idle && cmd_valid) begin
            m_act[i] = 1; m_rel[i] = 0; m_t3s[i] = -1; m_to[i] = 0;
            m_wr[i] = cmd_write;
            m_a[i]  = cmd_port;
            if (cmd_write) m_cdout[i] = cmd_data;
          end
        end
      end
      cyc++;
    end
  end

  function automatic logic [30:0] exp_vec(input int i);
    logic on;
    if (!reset_n) return {1'b1, 8'h00, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 8'h00};
    on = m_act[i] && (m_rel[i] >= TC);
    return {!m_act[i], m_a[i], m_cdout[i], m_act[i] && m_wr[i],
            !on, !(on && !m_wr[i]), !(on && m_wr[i]), m_rsp[i], m_rto[i], m_rdata[i]};
  endfunction

  // Compare both instances against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("outputs_dut0", {cmd_ready0, A0, cd_out0, cd_oe0, iorq_n0, rd_n0, wr_n0,
                           rsp_valid0, rsp_timeout0, rsp_data0}, exp_vec(0));
      chk("outputs_dut1", {cmd_ready1, A1, cd_out1, cd_oe1, iorq_n1, rd_n1, wr_n1,
                           rsp_valid1, rsp_timeout1, rsp_data1}, exp_vec(1));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int r_lat0, r_lat1, r_iorq0, r_rd0, r_wr0, r_oe0, r_oea0, r_iorq1;
  logic [7:0] r_rdat0, r_rdat1;
  logic r_to0, r_to1;

  task automatic issue(input logic w, input logic [7:0] p, input logic [7:0] d, output int acc);
    bit ok;
    @(negedge clk);
    cmd_write = w; cmd_port = p; cmd_data = d; cmd_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      if (cmd_ready0) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("issue_accepted", ok, 1);
    acc = cyc;
    @(posedge clk);
    #1;
    // Scramble the command inputs; the running cycle must not notice.
    cmd_valid = 1'b0; cmd_write = ~w; cmd_port = ~p; cmd_data = ~d;
  endtask

  task automatic collect(input int acc, input logic [7:0] port, input int wrel,
                         input int lim, input bit stop_on1);
    bit got0, got1;
    got0 = 0; got1 = 0;
    r_lat0 = -1; r_lat1 = -1; r_iorq0 = 0; r_rd0 = 0; r_wr0 = 0;
    r_oe0 = 0; r_oea0 = 0; r_iorq1 = 0;
    r_rdat0 = 8'h00; r_rdat1 = 8'h00; r_to0 = 1'b0; r_to1 = 1'b0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (wrel >= 0 && cyc - acc == wrel) wait_n = 1'b1;
      if (!got0) begin
        if (rsp_valid0) begin
          got0 = 1; r_lat0 = cyc - acc; r_rdat0 = rsp_data0; r_to0 = rsp_timeout0;
        end else begin
          if (!iorq_n0) r_iorq0++;
          if (!rd_n0) r_rd0++;
          if (!wr_n0) r_wr0++;
          if (cd_oe0) r_oe0++;
          if (cd_oe0 && A0 == port) r_oea0++;
        end
      end
      if (!got1) begin
        if (rsp_valid1) begin
          got1 = 1; r_lat1 = cyc - acc; r_rdat1 = rsp_data1; r_to1 = rsp_timeout1;
        end else if (!iorq_n1) begin
          r_iorq1++;
        end
      end
      if (stop_on1 ? got1 : got0) break;
    end
    if (stop_on1) chk("dut1_rsp_seen", got1, 1);
    else          chk("dut0_rsp_seen", got0, 1);
  endtask

  task automatic pulse_reset();
    int nr;
    nr = 0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_iorq_n", iorq_n0, 1'b1);
    chk("rst_async_wr_n",   wr_n0,   1'b1);
    chk("rst_async_rd_n",   rd_n0,   1'b1);
    chk("rst_async_cd_oe",  cd_oe0,  1'b0);
    chk("rst_async_A",      A0,      8'h00);
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid0) nr++;
      @(posedge clk);
    end
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready0", cmd_ready0, 1'b1);
    chk("rst_release_ready1", cmd_ready1, 1'b1);
    if (rsp_valid0) nr++;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid0) nr++;
    end
    chk("rst_no_rsp", nr, 0);
  endtask

  initial begin
    int acc, acc1, acc2, gap;
    bit ok;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_port = 8'h00;
    cmd_data = 8'h00; cd_in = 8'h00; wait_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_ready",    cmd_ready0, 1'b1);
    chk("reset_iorq_n",   iorq_n0,    1'b1);
    chk("reset_A",        A0,         8'h00);
    chk("reset_rsp_data", rsp_data0,  8'h00);
    chk("reset_cd_oe",    cd_oe0,     1'b0);

    // OUT 0x98 <- 0x5A, no extra waits.
    issue(1'b1, 8'h98, 8'h5A, acc);
    collect(acc, 8'h98, -1, 100, 1'b0);
    chk("wr_latency",   r_lat0,  25);
    chk("wr_iorq_low",  r_iorq0, 18);
    chk("wr_wr_low",    r_wr0,   18);
    chk("wr_rd_low",    r_rd0,   0);
    chk("wr_oe_high",   r_oe0,   24);
    chk("wr_A_with_oe", r_oea0,  24);
    chk("wr_timeout",   r_to0,   1'b0);
    chk("wr_A_held",    A0,      8'h98);
    repeat (2) @(negedge clk);

    // IN 0x99 with cd_in = 0xC3.
    cd_in = 8'hC3;
    issue(1'b0, 8'h99, 8'h00, acc);
    collect(acc, 8'h99, -1, 100, 1'b0);
    chk("rd_latency", r_lat0, 25);
    chk("rd_data",    r_rdat0, 8'hC3);
    chk("rd_oe_high", r_oe0,  0);
    chk("rd_rd_low",  r_rd0,  18);
    chk("rd_wr_low",  r_wr0,  0);
    repeat (2) @(negedge clk);

    // IN with wait_n low through the third TW: 4 TW on dut0, timeout on dut1.
    cd_in  = 8'h5E;
    wait_n = 1'b0;
    issue(1'b0, 8'h42, 8'h00, acc);
    collect(acc, 8'h42, 31, 200, 1'b0);
    chk("wait_latency0", r_lat0,  43);
    chk("wait_timeout0", r_to0,   1'b0);
    chk("wait_rd_low0",  r_rd0,   36);
    chk("wait_data0",    r_rdat0, 8'h5E);
    chk("wait_latency1", r_lat1,  37);
    chk("wait_timeout1", r_to1,   1'b1);
    chk("wait_data1",    r_rdat1, 8'h5E);
    repeat (2) @(negedge clk);

    // Back-to-back: cmd_valid held, fields changed during the first cycle.
    cd_in = 8'h77;
    @(negedge clk);
    cmd_write = 1'b1; cmd_port = 8'h10; cmd_data = 8'h11; cmd_valid = 1'b1;
    acc1 = cyc;
    @(posedge clk);
    #1;
    cmd_write = 1'b0; cmd_port = 8'h20; cmd_data = 8'hEE;
    ok = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (cmd_ready0) begin ok = 1; break; end
    end
    chk("b2b_second_ready", ok, 1);
    acc2 = cyc;
    chk("b2b_accept_gap",    acc2 - acc1, 25);
    chk("b2b_rsp_on_accept", rsp_valid0, 1'b1);
    gap = iorq_n0 ? 1 : 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (iorq_n0) gap++;
      else break;
    end
    // iorq_n stays high for the response clk plus the TC clks of the next T1.
    chk("b2b_iorq_high_gap", gap, TC + 1);
    collect(acc2, 8'h20, -1, 60, 1'b0);
    chk("b2b_latency2", r_lat0,  25);
    chk("b2b_data2",    r_rdat0, 8'h77);
    repeat (2) @(negedge clk);

    // OUT with wait_n held low: dut1 times out after 3 TW, dut0 is still waiting.
    wait_n = 1'b0;
    issue(1'b1, 8'h55, 8'hA5, acc);
    collect(acc, 8'h55, -1, 100, 1'b1);
    chk("to_latency1",    r_lat1,  37);
    chk("to_flag1",       r_to1,   1'b1);
    chk("to_iorq_low1",   r_iorq1, 30);
    chk("to_strobe_off1", iorq_n1, 1'b1);
    chk("to_dut0_wr_n",   wr_n0,   1'b0);
    chk("to_dut0_cd_oe",  cd_oe0,  1'b1);
    pulse_reset();
    wait_n = 1'b1;

    // IN that times out on dut1 still captures cd_in.
    wait_n = 1'b0;
    cd_in  = 8'h3C;
    issue(1'b0, 8'h7F, 8'h00, acc);
    collect(acc, 8'h7F, -1, 100, 1'b1);
    chk("tord_latency1", r_lat1,  37);
    chk("tord_flag1",    r_to1,   1'b1);
    chk("tord_data1",    r_rdat1, 8'h3C);
    pulse_reset();
    wait_n = 1'b1;

    // Normal cycle after reset.
    issue(1'b1, 8'h01, 8'h02, acc);
    collect(acc, 8'h01, -1, 100, 1'b0);
    chk("post_rst_latency", r_lat0, 25);
    chk("post_rst_oe",      r_oea0, 24);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
